control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter MD_WAIT, default 2: extra wait cycles before Zin for mul (01110) and div (01111).
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 clr  in  1  reset, synchronous and active-high.
REQ-004 IR  in  32  instruction register contents; opcode = IR[31:27].
REQ-005 con  in  1  branch condition from CON FF logic.
REQ-006 stop  in  1  pause request, sampled only in T0.
REQ-007 run  out  1  high while executing; low in HALT.
REQ-008 PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, IRin, wren  out  1 each  fetch and memory controls.
REQ-009 Yin, Zin, ZHIin, ZLOin, ZHIout, ZLOout, Cout, HIin, HIout, Loin, Loout  out  1 each  ALU-path controls.
REQ-010 Gra, Grb, Grc, Rin, Rout, BAout, CON_FF_In, InPortout, OPin  out  1 each  register-select and I/O controls.
REQ-011 ALUSelection  out  5  ALU operation code.

Function
REQ-012 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, br 10010, jr 10011, jal 10100, in 10101, out 10110, mfhi 10111, mflo 11000, nop 11001, halt 11010.
REQ-013 Moore FSM; outputs decode only the state register and latched opcode; every control not listed for a step is 0.
REQ-014 ALUSelection = opcode during ALU steps, 00011 (add) during address/offset steps, else 0.
REQ-015 Fetch: T0 PCout,MARin,IncPC; T1 MDRread,MDRin; T2 MDRout,IRin; opcode latched from IR at entry to T3.
REQ-016 Write-back WB(dst): Wa ZLOout+dst; shared by all ALU-result paths.
REQ-017 R-type add..rol: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin; T5 ZLOin,ZHIin; T6 Gra,Rin via WB; then T0.
REQ-018 mul/div: T3 Gra,Rout,Yin; MD_WAIT wait cycles with Grb,Rout held; then Zin; ZLOin,ZHIin; ZLOout,Loin; ZHIout,HIin; then T0.
REQ-019 addi/andi/ori: T3 Grb,Rout,Yin; T4 Cout,Zin; T5 ZLOin; T6 WB Gra,Rin.
REQ-020 neg/not: T3 Grb,Rout,Zin; T4 ZLOin; T5 WB Gra,Rin.
REQ-021 ld/ldi/st address: T3 Grb,BAout,Yin; T4 Cout,Zin; T5 ZLOin; ldi T6 WB Gra,Rin; ld T6 ZLOout,MARin, T7 MDRread,MDRin, T8 MDRout,Gra,Rin; st T6 ZLOout,MARin, T7 Gra,Rout,wren.
REQ-022 br: T3 Gra,Rout,CON_FF_In; T4 PCout,Yin; T5 Cout,Zin; T6 ZLOin; T7 ZLOout,PCin only if con=1 sampled in T7, else no control; then T0.
REQ-023 jr: T3 Gra,Rout,PCin. jal: T3 PCout,Grb... no: T3 PCout,Rin with R15 selected via Grb where IR[22:19]=1111 by convention; T4 Gra,Rout,PCin.
REQ-024 in: T3 InPortout,Gra,Rin. out: T3 Gra,Rout,OPin. mfhi: T3 HIout,Gra,Rin. mflo: T3 Loout,Gra,Rin.
REQ-025 nop and undefined opcodes: return to T0 after T2, no T3 controls.
REQ-026 halt: enter HALT; run=0; all controls 0; remain until clr.
REQ-027 stop=1 in T0: hold T0 with all controls 0 (PC not incremented); resume fetch on first T0 cycle with stop=0.
REQ-028 Every instruction ends by returning to T0; no state is reachable without passing T0 after clr.

Reset
REQ-029 clr=1 on a rising edge: state <= T0, latched opcode <= nop, run <= 1, regardless of current state including mid-instruction and HALT.
REQ-030 While clr=1, all control outputs are forced 0 combinationally.

Structure
REQ-031 Opcode constants, state encodings and ALU code 00011 live in shared cpu_defs package/include used by datapath and ALU.
REQ-032 One sub-module: ctrl_decode, combinational state+opcode to control-vector map; FSM sequencing stays in control_unit.

Verification
REQ-033 clr then IR=add R1,R2,R3 (0x18918000) -> T0..T6 sequence per REQ-015/017, Rin only in T6, return to T0 at cycle 8.
REQ-034 ld R1,0x54(R2) -> BAout in T3, MARin in T0 and T6, MDRread in T1 and T7, Gra+Rin in T8.
REQ-035 br with con=0 then con=1 -> PCin absent vs. asserted in T7 only.
REQ-036 mul with MD_WAIT=2 -> Zin in 3rd cycle after T3; Loin then HIin on consecutive cycles.
REQ-037 halt (0xD0000000) -> run=0, all controls 0 for 20 cycles; clr mid-HALT and mid-ld (T7) -> next cycle T0, run=1.
REQ-038 stop=1 for 5 cycles in T0 -> IncPC never asserted; fetch resumes cycle after stop drops.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcode constants, control-unit state encoding,
// opcode classes and the packed control vector used by the control unit,
// datapath and ALU.
package cpu_defs;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  // ALU code used for address and branch-offset arithmetic
  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_T8,
    ST_MDW, ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    CL_NOP, CL_RTYPE, CL_MD, CL_IMM, CL_UNARY, CL_LD, CL_LDI, CL_ST,
    CL_BR, CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_HALT
  } op_class_e;

  typedef struct packed {
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, mdr_read, ir_in, wren;
    logic y_in, z_in, zhi_in, zlo_in, zhi_out, zlo_out, c_out;
    logic hi_in, hi_out, lo_in, lo_out;
    logic gra, grb, grc, r_in, r_out, ba_out, con_ff_in, inport_out, op_in;
    logic [4:0] alu_sel;
  } ctrl_t;

  // Undefined opcodes fall into CL_NOP
  function automatic op_class_e op_class(input logic [4:0] op);
    op_class_e cl;
    cl = CL_NOP;
    case (op)
      OP_LD:   cl = CL_LD;
      OP_LDI:  cl = CL_LDI;
      OP_ST:   cl = CL_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: cl = CL_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:       cl = CL_IMM;
      OP_MUL, OP_DIV:                 cl = CL_MD;
      OP_NEG, OP_NOT:                 cl = CL_UNARY;
      OP_BR:   cl = CL_BR;
      OP_JR:   cl = CL_JR;
      OP_JAL:  cl = CL_JAL;
      OP_IN:   cl = CL_IN;
      OP_OUT:  cl = CL_OUT;
      OP_MFHI: cl = CL_MFHI;
      OP_MFLO: cl = CL_MFLO;
      OP_HALT: cl = CL_HALT;
      default: cl = CL_NOP;
    endcase
    return cl;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from (state, latched opcode) to the control vector.
// Ports: state - current FSM state; opcode - latched opcode;
//        ctrl - control vector; br_cond - this step's branch controls
//        are conditional on the CON flip-flop.
module ctrl_decode
  import cpu_defs::*;
(
  input  state_e     state,
  input  logic [4:0] opcode,
  output ctrl_t      ctrl,
  output logic       br_cond
);

  op_class_e cl;
  assign cl = op_class(opcode);

  always_comb begin
    ctrl    = '0;
    br_cond = 1'b0;
    case (state)
      ST_T0: begin ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; end
      ST_T1: begin ctrl.mdr_read = 1'b1; ctrl.mdr_in = 1'b1; end
      ST_T2: begin ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1; end
      ST_T3: begin
        case (cl)
          CL_RTYPE, CL_IMM: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
          CL_MD:    begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
          CL_UNARY: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_sel = opcode;
          end
          CL_LD, CL_LDI, CL_ST: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
          CL_BR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_ff_in = 1'b1; end
          CL_JR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
          CL_JAL:  begin ctrl.pc_out = 1'b1; ctrl.grb = 1'b1; ctrl.r_in = 1'b1; end
          CL_IN:   begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          CL_OUT:  begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.op_in = 1'b1; end
          CL_MFHI: begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          CL_MFLO: begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          default: ;
        endcase
      end
      // Multi-cycle mul/div keeps the second operand and op code presented
      ST_MDW: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.alu_sel = opcode; end
      ST_T4: begin
        case (cl)
          CL_RTYPE: begin
            ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_sel = opcode;
          end
          CL_MD: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_sel = opcode;
          end
          CL_IMM:   begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_sel = opcode; end
          CL_UNARY: ctrl.zlo_in = 1'b1;
          CL_LD, CL_LDI, CL_ST: begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_sel = ALU_ADD; end
          CL_BR:  begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
          CL_JAL: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cl)
          CL_RTYPE, CL_MD: begin ctrl.zlo_in = 1'b1; ctrl.zhi_in = 1'b1; end
          CL_IMM, CL_LD, CL_LDI, CL_ST: ctrl.zlo_in = 1'b1;
          CL_UNARY: begin ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          CL_BR: begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_sel = ALU_ADD; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (cl)
          CL_RTYPE, CL_IMM, CL_LDI: begin ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          CL_MD:        begin ctrl.zlo_out = 1'b1; ctrl.lo_in = 1'b1; end
          CL_LD, CL_ST: begin ctrl.zlo_out = 1'b1; ctrl.mar_in = 1'b1; end
          CL_BR:        ctrl.zlo_in = 1'b1;
          default: ;
        endcase
      end
      ST_T7: begin
        case (cl)
          CL_MD: begin ctrl.zhi_out = 1'b1; ctrl.hi_in = 1'b1; end
          CL_LD: begin ctrl.mdr_read = 1'b1; ctrl.mdr_in = 1'b1; end
          CL_ST: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.wren = 1'b1; end
          CL_BR: begin ctrl.zlo_out = 1'b1; ctrl.pc_in = 1'b1; br_cond = 1'b1; end
          default: ;
        endcase
      end
      ST_T8: if (cl == CL_LD) begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore control unit: sequences fetch and per-opcode execute steps and
// drives the datapath control lines.
// Ports: clk, clr (sync, active-high), IR (opcode IR[31:27]), con (CON FF),
//        stop (pause, sampled in T0); run plus all control strobes and
//        ALUSelection as outputs.
module control_unit
  import cpu_defs::*;
#(
  parameter int unsigned MD_WAIT = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        con,
  input  logic        stop,
  output logic        run,
  output logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, IRin, wren,
  output logic        Yin, Zin, ZHIin, ZLOin, ZHIout, ZLOout, Cout,
  output logic        HIin, HIout, Loin, Loout,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, CON_FF_In, InPortout, OPin,
  output logic [4:0]  ALUSelection
);

  localparam int unsigned WCW = (MD_WAIT > 1) ? $clog2(MD_WAIT) : 1;

  state_e         state, state_nxt;
  logic [4:0]     opq;
  logic [WCW-1:0] wait_cnt;
  ctrl_t          dec_ctrl, ctrl;
  logic           br_cond;
  op_class_e      cl_q, cl_ir;
  logic           unused_ir_bits;

  assign cl_q  = op_class(opq);
  assign cl_ir = op_class(IR[31:27]);
  // Operand fields are consumed by the datapath, not here
  assign unused_ir_bits = ^IR[26:0];

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= ST_T0;
      opq      <= OP_NOP;
      run      <= 1'b1;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      if (state == ST_T2) opq <= IR[31:27];
      if (state_nxt == ST_HALT) run <= 1'b0;
      wait_cnt <= (state == ST_MDW) ? wait_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_T0: state_nxt = stop ? ST_T0 : ST_T1;
      ST_T1: state_nxt = ST_T2;
      // The opcode is not latched yet, so branch on IR directly
      ST_T2: begin
        if (cl_ir == CL_NOP)       state_nxt = ST_T0;
        else if (cl_ir == CL_HALT) state_nxt = ST_HALT;
        else                       state_nxt = ST_T3;
      end
      ST_T3: begin
        case (cl_q)
          CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO: state_nxt = ST_T0;
          CL_MD:   state_nxt = (MD_WAIT > 0) ? ST_MDW : ST_T4;
          default: state_nxt = ST_T4;
        endcase
      end
      ST_MDW: state_nxt = (wait_cnt == WCW'(MD_WAIT - 1)) ? ST_T4 : ST_MDW;
      ST_T4: state_nxt = (cl_q == CL_JAL) ? ST_T0 : ST_T5;
      ST_T5: state_nxt = (cl_q == CL_UNARY) ? ST_T0 : ST_T6;
      ST_T6: begin
        case (cl_q)
          CL_RTYPE, CL_IMM, CL_LDI: state_nxt = ST_T0;
          default:                  state_nxt = ST_T7;
        endcase
      end
      ST_T7:   state_nxt = (cl_q == CL_LD) ? ST_T8 : ST_T0;
      ST_T8:   state_nxt = ST_T0;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_T0;
    endcase
  end

  ctrl_decode u_decode (
    .state   (state),
    .opcode  (opq),
    .ctrl    (dec_ctrl),
    .br_cond (br_cond)
  );

  // con is the registered CON flip-flop, so gating the branch step with it
  // keeps the outputs glitch-free; stop in T0 and clr blank everything.
  always_comb begin
    ctrl = dec_ctrl;
    if (br_cond && !con) begin
      ctrl.zlo_out = 1'b0;
      ctrl.pc_in   = 1'b0;
    end
    if (clr || (state == ST_T0 && stop)) ctrl = '0;
  end

  assign PCout        = ctrl.pc_out;
  assign PCin         = ctrl.pc_in;
  assign IncPC        = ctrl.inc_pc;
  assign MARin        = ctrl.mar_in;
  assign MDRin        = ctrl.mdr_in;
  assign MDRout       = ctrl.mdr_out;
  assign MDRread      = ctrl.mdr_read;
  assign IRin         = ctrl.ir_in;
  assign wren         = ctrl.wren;
  assign Yin          = ctrl.y_in;
  assign Zin          = ctrl.z_in;
  assign ZHIin        = ctrl.zhi_in;
  assign ZLOin        = ctrl.zlo_in;
  assign ZHIout       = ctrl.zhi_out;
  assign ZLOout       = ctrl.zlo_out;
  assign Cout         = ctrl.c_out;
  assign HIin         = ctrl.hi_in;
  assign HIout        = ctrl.hi_out;
  assign Loin         = ctrl.lo_in;
  assign Loout        = ctrl.lo_out;
  assign Gra          = ctrl.gra;
  assign Grb          = ctrl.grb;
  assign Grc          = ctrl.grc;
  assign Rin          = ctrl.r_in;
  assign Rout         = ctrl.r_out;
  assign BAout        = ctrl.ba_out;
  assign CON_FF_In    = ctrl.con_ff_in;
  assign InPortout    = ctrl.inport_out;
  assign OPin         = ctrl.op_in;
  assign ALUSelection = ctrl.alu_sel;

endmodule
